// File: rtl/xbar_nxm.sv
// N-master x M-slave request/response crossbar: address-decoded routing, per-slave
// round-robin arbitration, and in-order read-response return through per-slave ID FIFOs.
module xbar_nxm #(
  parameter  int N_MASTERS = 2,
  parameter  int N_SLAVES  = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int OUTST     = 4,
  localparam int SEL_W     = $clog2(N_SLAVES),
  localparam int ID_W      = $clog2(N_MASTERS),
  localparam int CNT_W     = $clog2(OUTST + 1),
  localparam int PTR_W     = (OUTST > 1) ? $clog2(OUTST) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          master_req,
  input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
  input  logic [N_MASTERS-1:0]          master_cmd,
  input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
  output logic [N_MASTERS-1:0]          master_ack,
  output logic [N_MASTERS-1:0]          master_resp,
  output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
  output logic [N_SLAVES-1:0]           slave_req,
  output logic [N_SLAVES*ADDR_W-1:0]    slave_addr,
  output logic [N_SLAVES-1:0]           slave_cmd,
  output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
  input  logic [N_SLAVES-1:0]           slave_ack,
  input  logic [N_SLAVES-1:0]           slave_resp,
  input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata
);

  logic [ADDR_W-1:0]    m_addr  [N_MASTERS];
  logic [DATA_W-1:0]    m_wdata [N_MASTERS];
  logic [SEL_W-1:0]     m_tgt   [N_MASTERS];
  logic [CNT_W-1:0]     rd_cnt  [N_MASTERS];
  logic [SEL_W-1:0]     rd_tgt  [N_MASTERS];
  logic [N_MASTERS-1:0] rd_inc, rd_dec;

  logic [N_MASTERS-1:0] elig    [N_SLAVES];
  logic [ID_W-1:0]      rr_ptr  [N_SLAVES];
  logic [ID_W-1:0]      win     [N_SLAVES];
  logic [N_SLAVES-1:0]  win_vld, accept, push, pop;

  logic [ID_W-1:0]      fifo_mem [N_SLAVES][OUTST];
  logic [PTR_W-1:0]     wr_ptr   [N_SLAVES];
  logic [PTR_W-1:0]     rd_ptr   [N_SLAVES];
  logic [CNT_W-1:0]     fifo_cnt [N_SLAVES];
  logic [ID_W-1:0]      head     [N_SLAVES];
  logic [N_SLAVES-1:0]  fifo_full, fifo_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      m_addr[m]  = master_addr[m*ADDR_W +: ADDR_W];
      m_wdata[m] = master_wdata[m*DATA_W +: DATA_W];
      m_tgt[m]   = master_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W];
    end
    for (int s = 0; s < N_SLAVES; s++) begin
      fifo_full[s]  = (fifo_cnt[s] == CNT_W'(OUTST));
      fifo_empty[s] = (fifo_cnt[s] == '0);
      head[s]       = fifo_mem[s][rd_ptr[s]];
    end
  end

  // A read may only join reads already in flight at the same slave, which keeps each
  // master's responses in order and prevents two slaves answering one master at once.
  always_comb begin
    for (int s = 0; s < N_SLAVES; s++) begin
      elig[s] = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
        if (master_req[m] && m_tgt[m] == SEL_W'(s)) begin
          elig[s][m] = master_cmd[m] ||
                       (!fifo_full[s] &&
                        (rd_cnt[m] == '0 ||
                         (rd_tgt[m] == SEL_W'(s) && rd_cnt[m] < CNT_W'(OUTST))));
        end
      end
    end
  end

  always_comb begin : arb
    logic [ID_W-1:0] idx;
    idx     = '0;
    win_vld = '0;
    for (int s = 0; s < N_SLAVES; s++) begin
      win[s] = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        idx = ID_W'((int'(rr_ptr[s]) + i) % N_MASTERS);
        if (!win_vld[s] && elig[s][idx]) begin
          win_vld[s] = 1'b1;
          win[s]     = idx;
        end
      end
    end
  end

  always_comb begin
    slave_req    = win_vld;
    slave_addr   = '0;
    slave_cmd    = '0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_resp  = '0;
    master_rdata = '0;
    rd_inc       = '0;
    rd_dec       = '0;
    for (int s = 0; s < N_SLAVES; s++) begin
      accept[s] = slave_ack[s] && win_vld[s];
      push[s]   = accept[s] && !master_cmd[win[s]];
      pop[s]    = slave_resp[s] && !fifo_empty[s];
      if (win_vld[s]) begin
        slave_addr[s*ADDR_W +: ADDR_W]  = m_addr[win[s]];
        slave_cmd[s]                    = master_cmd[win[s]];
        slave_wdata[s*DATA_W +: DATA_W] = m_wdata[win[s]];
      end
      if (accept[s]) master_ack[win[s]] = 1'b1;
      if (push[s])   rd_inc[win[s]]     = 1'b1;
      if (pop[s]) begin
        master_resp[head[s]] = 1'b1;
        rd_dec[head[s]]      = 1'b1;
      end
    end
    for (int m = 0; m < N_MASTERS; m++) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        if (pop[s] && head[s] == ID_W'(m))
          master_rdata[m*DATA_W +: DATA_W] = slave_rdata[s*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        rd_cnt[m] <= '0;
        rd_tgt[m] <= '0;
      end
      for (int s = 0; s < N_SLAVES; s++) begin
        rr_ptr[s]   <= '0;
        wr_ptr[s]   <= '0;
        rd_ptr[s]   <= '0;
        fifo_cnt[s] <= '0;
      end
    end else begin
      for (int m = 0; m < N_MASTERS; m++) begin
        rd_cnt[m] <= rd_cnt[m] + CNT_W'(rd_inc[m]) - CNT_W'(rd_dec[m]);
        if (rd_inc[m]) rd_tgt[m] <= m_tgt[m];
      end
      for (int s = 0; s < N_SLAVES; s++) begin
        if (accept[s])
          rr_ptr[s] <= (win[s] == ID_W'(N_MASTERS - 1)) ? '0 : win[s] + ID_W'(1);
        if (push[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
        if (pop[s])  rd_ptr[s] <= ptr_inc(rd_ptr[s]);
        fifo_cnt[s] <= fifo_cnt[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // NOTE: ID storage carries no reset; fifo_cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    for (int s = 0; s < N_SLAVES; s++) begin
      if (push[s]) fifo_mem[s][wr_ptr[s]] <= win[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        assert (!(slave_resp[s] && fifo_empty[s]))
          else $warning("xbar_nxm: slave %0d responded with no outstanding id, dropped", s);
      end
    end
  end

endmodule

// File: tb/tb_xbar_nxm.sv
// Directed bench for xbar_nxm (2x2): routing, round-robin order, outstanding limits,
// cross-slave read blocking and reset recovery, with read responses scoreboarded.
module tb_xbar_nxm;
  localparam int NM = 2, NS = 2, AW = 32, DW = 32, OUTST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    master_req, master_cmd, master_ack, master_resp;
  logic [NM*AW-1:0] master_addr;
  logic [NM*DW-1:0] master_wdata, master_rdata;
  logic [NS-1:0]    slave_req, slave_cmd, slave_ack, slave_resp;
  logic [NS*AW-1:0] slave_addr;
  logic [NS*DW-1:0] slave_wdata, slave_rdata;

  always #5 clk = ~clk;

  xbar_nxm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .OUTST(OUTST)) dut (
    .clk(clk), .rst(rst),
    .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
    .master_wdata(master_wdata), .master_ack(master_ack), .master_resp(master_resp),
    .master_rdata(master_rdata), .slave_req(slave_req), .slave_addr(slave_addr),
    .slave_cmd(slave_cmd), .slave_wdata(slave_wdata), .slave_ack(slave_ack),
    .slave_resp(slave_resp), .slave_rdata(slave_rdata)
  );

  typedef struct { int m; logic [DW-1:0] data; } resp_t;
  resp_t resp_q[$];
  int    ack_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    master_req = '0; master_cmd = '0; master_addr = '0; master_wdata = '0;
    slave_ack = '0; slave_resp = '0; slave_rdata = '0;
  endtask

  task automatic drive_m(input int m, input logic cmd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    master_req[m] = 1'b1;
    master_cmd[m] = cmd;
    master_addr[m*AW +: AW]  = a;
    master_wdata[m*DW +: DW] = d;
  endtask

  task automatic slave_respond(input int s, input logic [DW-1:0] d, input int m);
    resp_t r;
    slave_resp[s] = 1'b1;
    slave_rdata[s*DW +: DW] = d;
    r.m = m;
    r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic check_resp(input string tag);
    resp_t r;
    logic [NM-1:0] oh;
    if (resp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      r  = resp_q.pop_front();
      oh = NM'(1) << r.m;
      check({tag, "_resp"}, 64'(master_resp), 64'(oh));
      check({tag, "_rdata"}, 64'(master_rdata[r.m*DW +: DW]), 64'(r.data));
      check({tag, "_rdata_other"}, 64'(master_rdata[(1-r.m)*DW +: DW]), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mack"},  64'(master_ack), 64'd0);
    check({tag, "_mresp"}, 64'(master_resp), 64'd0);
    check({tag, "_sreq"},  64'(slave_req), 64'd0);
    check({tag, "_saddr"}, 64'(slave_addr), 64'd0);
    check({tag, "_swd"},   64'(slave_wdata), 64'd0);
    check({tag, "_mrd"},   64'(master_rdata), 64'd0);
  endtask

  initial begin
    int acks;
    logic [DW-1:0] wd [NM];

    // Reset state
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Direct write m0 -> s0
    drive_m(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    slave_ack = 2'b01;
    settle();
    check("dw_sreq",  64'(slave_req), 64'h1);
    check("dw_saddr", 64'(slave_addr[0 +: AW]), 64'h10);
    check("dw_swd",   64'(slave_wdata[0 +: DW]), 64'hDEAD_BEEF);
    check("dw_scmd",  64'(slave_cmd[0]), 64'h1);
    check("dw_mack",  64'(master_ack), 64'h1);
    tick();
    idle();

    // Cross read m0 -> s1, response two cycles after the ack
    drive_m(0, 1'b0, 32'h8000_0004, '0);
    slave_ack = 2'b10;
    settle();
    check("cr_sreq",  64'(slave_req), 64'h2);
    check("cr_saddr", 64'(slave_addr[AW +: AW]), 64'h8000_0004);
    check("cr_mack",  64'(master_ack), 64'h1);
    tick();
    idle();
    settle();
    check("cr_idle_resp", 64'(master_resp), 64'h0);
    tick();
    slave_respond(1, 32'h1234_5678, 0);
    settle();
    check_resp("cr");
    tick();
    idle();

    // Arbitration from a fresh pointer: both masters write s0 continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wd[0] = 32'hA000_0000;
    wd[1] = 32'hB000_0001;
    drive_m(0, 1'b1, 32'h0000_0100, wd[0]);
    drive_m(1, 1'b1, 32'h0000_0200, wd[1]);
    slave_ack = 2'b01;
    for (int i = 0; i < 6; i++) ack_q.push_back(i % 2);
    for (int i = 0; i < 6; i++) begin
      int exp_m;
      settle();
      exp_m = ack_q.pop_front();
      check($sformatf("arb_ack%0d", i), 64'(master_ack), 64'(NM'(1) << exp_m));
      check($sformatf("arb_wd%0d", i), 64'(slave_wdata[0 +: DW]), 64'(wd[exp_m]));
      tick();
    end
    idle();

    // Outstanding limit: m0 keeps requesting reads on s1
    drive_m(0, 1'b0, 32'h8000_0000, '0);
    slave_ack = 2'b10;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (master_ack[0]) acks++;
      tick();
    end
    check("ol_acks", 64'(acks), 64'd4);
    settle();
    check("ol_held_sreq", 64'(slave_req), 64'h0);
    slave_respond(1, 32'h0000_A0A0, 0);
    settle();
    check_resp("ol_r0");
    check("ol_no_bypass", 64'(master_ack), 64'h0);
    tick();
    slave_resp = '0;
    settle();
    check("ol_fifth_ack", 64'(master_ack), 64'h1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      slave_respond(1, 32'h0000_B000 + DW'(i), 0);
      settle();
      check_resp($sformatf("ol_drain%0d", i));
      tick();
      slave_resp = '0;
    end
    settle();
    check("ol_drained", 64'(master_resp), 64'h0);

    // Cross-slave block: m1 has a read on s0 and tries a read on s1
    drive_m(1, 1'b0, 32'h0000_0040, '0);
    slave_ack = 2'b01;
    settle();
    check("cs_rd0_ack", 64'(master_ack), 64'h2);
    tick();
    idle();
    drive_m(1, 1'b0, 32'h8000_0040, '0);
    slave_ack = 2'b10;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("cs_blocked%0d", i), 64'(master_ack), 64'h0);
      check($sformatf("cs_sreq%0d", i), 64'(slave_req), 64'h0);
      tick();
    end
    master_cmd[1] = 1'b1;
    master_wdata[DW +: DW] = 32'h0000_0C0C;
    settle();
    check("cs_wr_ack", 64'(master_ack), 64'h2);
    tick();
    master_cmd[1] = 1'b0;
    slave_respond(0, 32'h0000_0055, 1);
    settle();
    check_resp("cs_r0");
    check("cs_still_blocked", 64'(master_ack), 64'h0);
    tick();
    slave_resp = '0;
    settle();
    check("cs_rd1_ack", 64'(master_ack), 64'h2);
    tick();
    idle();
    slave_respond(1, 32'h0000_0066, 1);
    settle();
    check_resp("cs_r1");
    tick();
    idle();

    // Reset with three reads outstanding on s0
    drive_m(0, 1'b0, 32'h0000_0000, '0);
    slave_ack = 2'b01;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (master_ack[0]) acks++;
      tick();
    end
    check("rs_acks", 64'(acks), 64'd3);
    idle();
    rst = 1'b1;
    settle();
    check_all_zero("rs_during");
    tick();
    rst = 1'b0;
    slave_resp = 2'b01;
    slave_rdata[0 +: DW] = 32'h0000_0077;
    settle();
    check("rs_dropped_resp", 64'(master_resp), 64'h0);
    check("rs_dropped_rdata", 64'(master_rdata), 64'h0);
    tick();
    idle();
    drive_m(0, 1'b0, 32'h0000_0008, '0);
    slave_ack = 2'b01;
    settle();
    check("rs_new_ack", 64'(master_ack), 64'h1);
    tick();
    idle();
    slave_respond(0, 32'h0000_0088, 0);
    settle();
    check_resp("rs_new");
    tick();
    idle();

    check("sb_empty_end", 64'(resp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
